// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: FSM states, memory read/write
// polarity and the default MFC timeout.
// Latency: n/a (package). Backpressure: n/a.
package mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_STROBE   = 3'd2,
    S_WAIT_MFC = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  // Polarity of the memory's rw line.
  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  // Cycles allowed for each MFC edge before giving up.
  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Latency: 2 clk cycles. Backpressure: none, the level is sampled every cycle.
// Ports: clk, rst (async active-high), d (async input), q (synchronized output).
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between a fetch port and a data port sharing one
// asynchronous en/MFC memory. Latency: 6 cycles request->ack when MFC answers
// within a cycle of en. Backpressure: one transaction in flight; a requester
// holds req until its one-cycle ack, the other port waits in IDLE.
// Ports: f_* fetch request/ack/rdata, d_* data request/ack/rdata,
//        mem_* memory strobe/bus/MFC, busy = FSM not in IDLE.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic              f_err,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_mfc,
  output logic              busy
);

  localparam int              CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic             last_data;   // 1: data port was the most recent winner
  logic             sel_data;    // owner of the transaction in flight
  logic [CNT_W-1:0] cnt;
  logic             mfc_s;

  logic             grant, grant_data;
  logic             done_ok, done_to;
  logic             cnt_clr, cnt_inc;

  sync2 u_mfc_sync (
    .clk (clk),
    .rst (rst),
    .d   (mem_mfc),
    .q   (mfc_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    // Data wins when alone, or on a tie when fetch was served last.
    grant_data = d_req & (~f_req | ~last_data);
    case (state)
      S_IDLE: begin
        if (f_req | d_req) begin
          grant     = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: state_nxt = S_STROBE;
      S_STROBE: begin
        cnt_clr   = 1'b1;
        state_nxt = S_WAIT_MFC;
      end
      S_WAIT_MFC: begin
        // MFC is checked before the timeout so a last-cycle answer still counts.
        if (mfc_s) begin
          done_ok   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = S_RELEASE;
        end else if (cnt == CNT_MAX) begin
          done_to   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = S_RELEASE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_RELEASE: begin
        // Wait for MFC to fall so the next strobe sees a clean rising edge;
        // a stuck-high MFC is abandoned silently after TIMEOUT cycles.
        if (!mfc_s || cnt == CNT_MAX) state_nxt = S_IDLE;
        else                          cnt_inc   = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_data <= 1'b1;
      sel_data  <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_rw    <= MEM_READ;
      mem_addr  <= '0;
      mem_wdata <= '0;
      f_ack     <= 1'b0;
      f_err     <= 1'b0;
      f_rdata   <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      f_ack <= 1'b0;
      f_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      busy  <= (state_nxt != S_IDLE);

      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;

      if (grant) begin
        sel_data  <= grant_data;
        last_data <= grant_data;
        if (grant_data) begin
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          mem_rw    <= d_we ? MEM_WRITE : MEM_READ;
        end else begin
          mem_addr  <= f_addr;
          mem_rw    <= MEM_READ;
        end
      end

      if (state == S_STROBE) mem_en <= 1'b1;

      if (done_ok || done_to) begin
        mem_en <= 1'b0;
        if (sel_data) begin
          d_ack <= 1'b1;
          d_err <= done_to;
          if (done_ok && mem_rw == MEM_READ) d_rdata <= mem_rdata;
        end else begin
          f_ack <= 1'b1;
          f_err <= done_to;
          if (done_ok) f_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
